// File: rtl/bundle_job_scheduler.sv
// bundle_job_scheduler: round-robin sharing of one bundle kernel generator, with watchdog abort
module bundle_job_scheduler #(
  parameter int NUM_REQ          = 4,
  parameter int HV_ADDRESS_WIDTH = 20,
  parameter int TIMEOUT_CYCLES   = 65535,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0]  req_hva,
  input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0]  req_hvb,
  input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0]  req_hvc,
  input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0]  req_offset,
  input  logic [NUM_REQ-1:0]                   req_mode,
  output logic [NUM_REQ-1:0]                   ack,
  output logic [NUM_REQ-1:0]                   cmp,
  output logic                                 cmp_err,
  output logic                                 k_valid,
  output logic [HV_ADDRESS_WIDTH-1:0]          k_hva,
  output logic [HV_ADDRESS_WIDTH-1:0]          k_hvb,
  output logic [HV_ADDRESS_WIDTH-1:0]          k_hvc,
  output logic [HV_ADDRESS_WIDTH-1:0]          k_hv_offset,
  output logic                                 k_mode,
  input  logic                                 k_done,
  output logic                                 busy,
  output logic [CNT_WIDTH-1:0]                 jobs_done
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = HV_ADDRESS_WIDTH;
  localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_win, w_win;
  logic [WW-1:0] r_wd;
  logic w_any, w_end;
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!w_any && req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_win = IW'((int'(r_ptr) + k) % NUM_REQ);
      end
    w_end = r_state == WAIT && (k_done || (TIMEOUT_CYCLES != 0 && r_wd == WD_LAST));
    w_next = r_state == IDLE  ? (w_any ? ISSUE : IDLE) :
             r_state == ISSUE ? WAIT :
             r_state == WAIT  ? (w_end ? COMPLETE : WAIT) : IDLE;
  end
  // every output is a register loaded from the next state, so it lines up with that state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_wd        <= '0;
      ack         <= '0;
      cmp         <= '0;
      cmp_err     <= 1'b0;
      k_valid     <= 1'b0;
      k_hva       <= '0;
      k_hvb       <= '0;
      k_hvc       <= '0;
      k_hv_offset <= '0;
      k_mode      <= 1'b0;
      busy        <= 1'b0;
      jobs_done   <= '0;
    end else begin
      r_state <= w_next;
      busy    <= w_next != IDLE;
      k_valid <= w_next == ISSUE;
      ack     <= w_next == ISSUE ? NUM_REQ'(1) << w_win : '0;
      cmp     <= w_end ? NUM_REQ'(1) << r_win : '0;
      cmp_err <= w_end && !k_done;
      r_wd    <= r_state == WAIT && !w_end ? r_wd + 1'b1 : '0;
      if (w_end && k_done) jobs_done <= jobs_done + 1'b1;
      if (r_state == IDLE && w_any) begin
        r_win       <= w_win;
        r_ptr       <= w_win == IW'(NUM_REQ - 1) ? '0 : w_win + 1'b1;
        k_hva       <= req_hva[int'(w_win)*HW +: HW];
        k_hvb       <= req_hvb[int'(w_win)*HW +: HW];
        k_hvc       <= req_hvc[int'(w_win)*HW +: HW];
        k_hv_offset <= req_offset[int'(w_win)*HW +: HW];
        k_mode      <= req_mode[w_win];
      end
    end
endmodule

// File: tb/tb_bundle_job_scheduler.sv
// tb_bundle_job_scheduler: scoreboard bench, main instance plus an 8-cycle watchdog instance
module tb_bundle_job_scheduler;
  localparam int N = 4;
  localparam int W = 20;
  logic clk = 0, reset_n = 0;
  logic [N-1:0] req = '0, wd_req = '0, req_mode = '0;
  logic [N*W-1:0] req_hva = '0, req_hvb = '0, req_hvc = '0, req_offset = '0;
  logic k_done = 0, wd_k_done = 0;
  logic [N-1:0] ack, cmp, wd_ack, wd_cmp;
  logic cmp_err, k_valid, k_mode, busy, wd_cmp_err, wd_k_valid, wd_k_mode, wd_busy;
  logic [W-1:0] k_hva, k_hvb, k_hvc, k_hv_offset, wd_k_hva, wd_k_hvb, wd_k_hvc, wd_k_hv_offset;
  logic [15:0] jobs_done, wd_jobs_done;
  int checks = 0, errors = 0;
  int q_grant[$];
  logic [N:0] q_cmp[$];

  bundle_job_scheduler u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_hva(req_hva), .req_hvb(req_hvb),
    .req_hvc(req_hvc), .req_offset(req_offset), .req_mode(req_mode), .ack(ack), .cmp(cmp),
    .cmp_err(cmp_err), .k_valid(k_valid), .k_hva(k_hva), .k_hvb(k_hvb), .k_hvc(k_hvc),
    .k_hv_offset(k_hv_offset), .k_mode(k_mode), .k_done(k_done), .busy(busy), .jobs_done(jobs_done));

  bundle_job_scheduler #(.TIMEOUT_CYCLES(8)) u_wd (
    .clk(clk), .reset_n(reset_n), .req(wd_req), .req_hva(req_hva), .req_hvb(req_hvb),
    .req_hvc(req_hvc), .req_offset(req_offset), .req_mode(req_mode), .ack(wd_ack), .cmp(wd_cmp),
    .cmp_err(wd_cmp_err), .k_valid(wd_k_valid), .k_hva(wd_k_hva), .k_hvb(wd_k_hvb), .k_hvc(wd_k_hvc),
    .k_hv_offset(wd_k_hv_offset), .k_mode(wd_k_mode), .k_done(wd_k_done), .busy(wd_busy),
    .jobs_done(wd_jobs_done));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset;
    reset_n = 0; req = '0; wd_req = '0; k_done = 0; wd_k_done = 0;
    q_grant.delete(); q_cmp.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] a, b, c, o, input logic m);
    req_hva[i*W +: W] = a; req_hvb[i*W +: W] = b; req_hvc[i*W +: W] = c;
    req_offset[i*W +: W] = o; req_mode[i] = m;
  endtask

  task automatic wait_ack(input bit wd, output logic [N-1:0] a);
    a = '0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      a = wd ? wd_ack : ack;
      if (a != '0) break;
    end
  endtask

  task automatic wait_cmp(input bit wd, output logic [N-1:0] c, output logic e, output int n);
    n = 0; c = '0; e = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      n++;
      c = wd ? wd_cmp : cmp;
      e = wd ? wd_cmp_err : cmp_err;
      if (c != '0) break;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({ack, cmp, cmp_err, k_valid, busy} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {ack, cmp, cmp_err, k_valid, busy});
    end
    checks++;
    if ({k_hva, k_hvb, k_hvc, k_hv_offset, k_mode} !== '0) begin
      errors++; $display("FAIL reset_fields: got %h want 0", {k_hva, k_hvb, k_hvc, k_hv_offset, k_mode});
    end
    checks++;
    if (jobs_done !== 16'd0) begin
      errors++; $display("FAIL reset_jobs_done: got %0d want 0", jobs_done);
    end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int exp, bad;
    logic [N:0] e;
    set_slice(1, 20'h100, 20'h200, 20'h300, 20'h10, 1'b1);
    req = 4'b0010;
    q_grant.push_back(1); q_cmp.push_back({1'b0, 4'b0010});
    @(negedge clk);
    exp = q_grant.pop_front();
    checks++;
    if ({k_valid, ack} !== {1'b1, 4'(1 << exp)}) begin
      errors++; $display("FAIL single_latency: got k_valid/ack %b want %b", {k_valid, ack}, {1'b1, 4'(1 << exp)});
    end
    req = '0;
    bad = 0;
    for (int i = 1; i < 21; i++) begin
      @(negedge clk);
      if ({k_hva, k_hvb, k_hvc, k_hv_offset, k_mode} !== {20'h100, 20'h200, 20'h300, 20'h10, 1'b1} ||
          cmp !== '0 || k_valid !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL single_hold: got %0d bad WAIT cycles want 0", bad);
    end
    k_done = 1;
    @(negedge clk);
    k_done = 0;
    e = q_cmp.pop_front();
    checks++;
    if ({cmp_err, cmp} !== e) begin
      errors++; $display("FAIL single_cmp: got %b want %b", {cmp_err, cmp}, e);
    end
    @(negedge clk);
    checks++;
    if (jobs_done !== 16'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: got jobs_done=%0d busy=%b want 1/0", jobs_done, busy);
    end
  endtask

  task automatic test_round_robin;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    int exp;
    logic [N-1:0] a;
    logic [N:0] e;
    do_reset();
    for (int i = 0; i < N; i++)
      set_slice(i, 20'(32'h1000 + i), 20'(32'h2000 + i), 20'(32'h3000 + i), 20'(32'h40 + i), 1'(i));
    foreach (order[i]) q_grant.push_back(order[i]);
    req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      wait_ack(0, a);
      exp = q_grant.pop_front();
      checks++;
      if (a !== 4'(1 << exp) || k_hva !== 20'(32'h1000 + exp)) begin
        errors++; $display("FAIL rr_grant%0d: got ack=%b hva=%h want %b %h", n, a, k_hva, 4'(1 << exp), 20'(32'h1000 + exp));
      end
      q_cmp.push_back({1'b0, 4'(1 << exp)});
      req = req & ~a;
      @(negedge clk);
      k_done = 1;
      @(negedge clk);
      k_done = 0;
      e = q_cmp.pop_front();
      checks++;
      if ({cmp_err, cmp} !== e) begin
        errors++; $display("FAIL rr_cmp%0d: got %b want %b", n, {cmp_err, cmp}, e);
      end
      req = n == 5 ? '0 : req | 4'(1 << exp);
    end
    @(negedge clk);
  endtask

  task automatic test_pointer_wrap;
    int nxt[3] = '{5, 4, 0};
    int exp;
    logic [N-1:0] a;
    do_reset();
    q_grant.push_back(2); q_grant.push_back(0); q_grant.push_back(2);
    req = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      wait_ack(0, a);
      exp = q_grant.pop_front();
      checks++;
      if (a !== 4'(1 << exp)) begin
        errors++; $display("FAIL wrap_grant%0d: got %b want %b", n, a, 4'(1 << exp));
      end
      req = req & ~a;
      @(negedge clk);
      k_done = 1;
      @(negedge clk);
      k_done = 0;
      req = 4'(nxt[n]);
    end
    @(negedge clk);
  endtask

  task automatic test_watchdog;
    int exp, n;
    logic [N-1:0] a, c;
    logic er;
    logic [N:0] e;
    do_reset();
    wd_req = 4'b0001;
    q_grant.push_back(0); q_cmp.push_back({1'b1, 4'b0001});
    wait_ack(1, a);
    exp = q_grant.pop_front();
    checks++;
    if (a !== 4'(1 << exp)) begin
      errors++; $display("FAIL wd_grant: got %b want %b", a, 4'(1 << exp));
    end
    wd_req = '0;
    wait_cmp(1, c, er, n);
    e = q_cmp.pop_front();
    checks++;
    if ({er, c} !== e || n != 9) begin
      errors++; $display("FAIL wd_abort: got %b after %0d cycles want %b after 9", {er, c}, n, e);
    end
    @(negedge clk);
    checks++;
    if (wd_jobs_done !== 16'd0) begin
      errors++; $display("FAIL wd_jobs_unchanged: got %0d want 0", wd_jobs_done);
    end
    wd_req = 4'b0010;
    wait_ack(1, a);
    checks++;
    if (a !== 4'b0010) begin
      errors++; $display("FAIL wd_next_grant: got %b want 0010", a);
    end
    wd_req = '0;
    @(negedge clk);
    wd_k_done = 1;
    @(negedge clk);
    wd_k_done = 0;
    checks++;
    if ({wd_cmp_err, wd_cmp} !== 5'b0_0010) begin
      errors++; $display("FAIL wd_next_cmp: got %b want 00010", {wd_cmp_err, wd_cmp});
    end
    @(negedge clk);
    checks++;
    if (wd_jobs_done !== 16'd1) begin
      errors++; $display("FAIL wd_next_jobs: got %0d want 1", wd_jobs_done);
    end
  endtask

  task automatic test_spurious;
    int n;
    logic [N-1:0] a, c;
    logic er;
    wd_req = 4'b0100;
    wait_ack(1, a);
    wd_req = '0;
    wd_k_done = 1;
    @(negedge clk);
    wd_k_done = 0;
    wait_cmp(1, c, er, n);
    checks++;
    if ({er, c} !== 5'b1_0100 || n != 8) begin
      errors++; $display("FAIL spurious_ignored: got %b after %0d cycles want 10100 after 8", {er, c}, n);
    end
    wd_req = 4'b1000;
    wait_ack(1, a);
    checks++;
    if (a !== 4'b1000) begin
      errors++; $display("FAIL simul_grant: got %b want 1000", a);
    end
    wd_req = '0;
    repeat (7) @(negedge clk);
    @(negedge clk);
    wd_k_done = 1;
    @(negedge clk);
    wd_k_done = 0;
    checks++;
    if ({wd_cmp_err, wd_cmp} !== 5'b0_1000) begin
      errors++; $display("FAIL simul_done_wins: got %b want 01000", {wd_cmp_err, wd_cmp});
    end
    @(negedge clk);
    checks++;
    if (wd_jobs_done !== 16'd2) begin
      errors++; $display("FAIL simul_jobs: got %0d want 2", wd_jobs_done);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [N-1:0] a;
    int bad;
    do_reset();
    req = 4'b0001;
    wait_ack(0, a);
    req = '0;
    @(negedge clk);
    k_done = 1;
    @(negedge clk);
    k_done = 0;
    req = 4'b0001;
    wait_ack(0, a);
    req = '0;
    repeat (3) @(negedge clk);
    reset_n = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || jobs_done !== 16'd0) begin
      errors++; $display("FAIL rst_async: got busy=%b jobs_done=%0d want 0/0", busy, jobs_done);
    end
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (cmp !== '0 || busy !== 1'b0) bad++;
    end
    reset_n = 1;
    repeat (3) begin
      @(negedge clk);
      if (cmp !== '0 || busy !== 1'b0 || jobs_done !== 16'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rst_quiet: got %0d bad cycles want 0", bad);
    end
    req = 4'b0011;
    wait_ack(0, a);
    checks++;
    if (a !== 4'b0001) begin
      errors++; $display("FAIL rst_ptr: got %b want 0001", a);
    end
    req = '0;
    @(negedge clk);
    k_done = 1;
    @(negedge clk);
    k_done = 0;
    req = 4'b1000;
    wait_ack(0, a);
    checks++;
    if (a !== 4'b1000) begin
      errors++; $display("FAIL rst_new_grant: got %b want 1000", a);
    end
    req = '0;
    @(negedge clk);
    k_done = 1;
    @(negedge clk);
    k_done = 0;
    @(negedge clk);
    checks++;
    if (jobs_done !== 16'd2) begin
      errors++; $display("FAIL rst_jobs: got %0d want 2", jobs_done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_watchdog();
    test_spurious();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bundle_job_scheduler.md
Name: bundle_job_scheduler

Overview:
Round-robin scheduler that shares one bundle kernel generator among NUM_REQ requesters.
It accepts one bundle job at a time (operand addresses, offset, mode) and presents it to the generator with a single-cycle valid. It then waits for the generator's done pulse and returns a per-requester completion pulse.
A watchdog aborts jobs whose done never arrives.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HV_ADDRESS_WIDTH, 20, width of each hypervector address field
TIMEOUT_CYCLES, 65535, max WAIT cycles before abort; 0 disables watchdog
CNT_WIDTH, 16, width of completed-job counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester job request, level
req_hva  in  NUM_REQ*HV_ADDRESS_WIDTH  packed A address, slice i = requester i
req_hvb  in  NUM_REQ*HV_ADDRESS_WIDTH  packed B address
req_hvc  in  NUM_REQ*HV_ADDRESS_WIDTH  packed C (result) address
req_offset  in  NUM_REQ*HV_ADDRESS_WIDTH  packed hv_offset
req_mode  in  NUM_REQ  bundling mode (0 = A&B, 1 = A->B)
ack  out  NUM_REQ  one-cycle pulse: job of requester i accepted
cmp  out  NUM_REQ  one-cycle pulse: job of requester i finished
cmp_err  out  1  valid with cmp; 1 = job aborted by watchdog
k_valid  out  1  one-cycle start pulse to generator
k_hva, k_hvb, k_hvc, k_hv_offset  out  HV_ADDRESS_WIDTH each  job fields to generator
k_mode  out  1  mode to generator
k_done  in  1  generator done pulse
busy  out  1  1 whenever state != IDLE
jobs_done  out  CNT_WIDTH  count of successful completions, wraps

Behaviour:
- Interface: one clock `clk`; reset is asynchronous and active-low on `reset_n`.
- Reset values: state IDLE; ack, cmp, cmp_err, k_valid, busy = 0. k_* fields = 0. jobs_done = 0. RR pointer = 0. Watchdog counter = 0.
- FSM states: IDLE, ISSUE, WAIT, COMPLETE.
- IDLE:
  - If req != 0, choose a winner: the first set bit at or after the RR pointer, searching upward with wrap at NUM_REQ.
  - Register the winner index and copy its slice of all req_* fields into k_*.
  - Set RR pointer = (winner+1) mod NUM_REQ.
  - Go to ISSUE.
  - If req == 0, stay in IDLE; the pointer is unchanged.
- ISSUE (exactly 1 cycle):
  - k_valid = 1 and ack[winner] = 1 together; then go to WAIT.
  - Latency from req sampled high in IDLE to ack/k_valid is 1 cycle.
- WAIT:
  - k_* are held stable for the whole job.
  - The watchdog increments every cycle.
  - k_done = 1 takes precedence over timeout in the same cycle: go to COMPLETE with err = 0.
  - Otherwise, when TIMEOUT_CYCLES != 0 and watchdog == TIMEOUT_CYCLES-1, go to COMPLETE with err = 1.
- COMPLETE (exactly 1 cycle):
  - cmp[winner] = 1 and cmp_err = err.
  - jobs_done increments only if err = 0.
  - Watchdog clears; go to IDLE.
- k_done is sampled only in WAIT; a pulse in IDLE/ISSUE/COMPLETE is ignored.
- req is ignored outside IDLE. A requester holds req and its fields stable until its ack, and must drop req in the cycle after ack unless it has a new job.
- Minimum job turnaround is 4 cycles (IDLE, ISSUE, WAIT≥1, COMPLETE). Back-to-back requests from different requesters alternate fairly.
- k_valid is never asserted while a job is outstanding; at most one job is in flight.
- Reset asserted mid-job forces all state back to reset values immediately. No cmp is produced for the lost job.
- Single requester permanently requesting is served every turnaround with no idle gaps beyond IDLE.
- All outputs are registered.

Test Plan:
- Single job: req=4'b0010 with hva=0x100, hvb=0x200, hvc=0x300, offset=0x10, mode=1; generator done 20 cycles after k_valid. Required: ack[1] and k_valid on the cycle after req is sampled. k_hva..k_mode equal the slice-1 values throughout WAIT. cmp[1] one cycle after k_done with cmp_err=0. jobs_done=1.
- Round robin: all four req held high, each dropped after its ack, then re-raised. Required: grant order 0,1,2,3,0,1; no requester is granted twice before all others are served.
- Pointer wrap: pointer=3 after granting 2, then req=4'b0101. Required: grant 0 first, then 2.
- Watchdog: TIMEOUT_CYCLES=8, generator never pulses done. Required: cmp[i]=1 with cmp_err=1 exactly 8 WAIT cycles after ISSUE; jobs_done unchanged; next request served normally.
- Spurious/simultaneous: k_done pulsed in ISSUE is ignored. k_done on the same cycle as the timeout gives cmp_err=0.
- Reset mid-WAIT: reset_n low for 2 cycles during WAIT. Required: busy=0, no cmp, jobs_done=0, RR pointer=0; a new req=4'b1000 is granted normally after reset release.
